// File: rtl/pe_au_pkg.sv
// rtl/pe_au_pkg.sv - shared types and helpers for the PE arithmetic unit
// Contents: op_t final-stage operation codes, OP_W, pe_au_latency().
package pe_au_pkg;

    localparam int OP_W = 3;

    // Final-stage operations; code 7 is reserved and treated as a hold.
    typedef enum logic [OP_W-1:0] {
        OP_MUL         = 3'd0,
        OP_MAC_C       = 3'd1,
        OP_MAC_SHIFT   = 3'd2,
        OP_MAC_C_SHIFT = 3'd3,
        OP_ADD_C       = 3'd4,
        OP_HOLD        = 3'd5,
        OP_CLR         = 3'd6,
        OP_RSVD        = 3'd7
    } op_t;

    // Issue-to-result latency in cycles.
    function automatic int pe_au_latency(input int abreg, input int mreg);
        return 1 + abreg + mreg;
    endfunction

endpackage

// File: rtl/pe_au_param_if.sv
// rtl/pe_au_param_if.sv - issue/result bundle of the PE arithmetic unit
// Signals: valid_i/op_i/A_i/B_i issue, C_i/CREG_en_i addend, P_o/valid_o result.
// Modports: master drives issues (producer), slave is the arithmetic unit.
interface pe_au_param_if #(
    parameter int WIDTH = 17
);
    import pe_au_pkg::*;

    logic               valid_i;
    op_t                op_i;
    logic [WIDTH-1:0]   A_i;
    logic [WIDTH-1:0]   B_i;
    logic [2*WIDTH-1:0] C_i;
    logic               CREG_en_i;
    logic [2*WIDTH+1:0] P_o;
    logic               valid_o;

    modport master (
        output valid_i, op_i, A_i, B_i, C_i, CREG_en_i,
        input  P_o, valid_o
    );

    modport slave (
        input  valid_i, op_i, A_i, B_i, C_i, CREG_en_i,
        output P_o, valid_o
    );

endinterface

// File: rtl/pe_au_delay_line.sv
// rtl/pe_au_delay_line.sv - reset-free data shift register, DEPTH=0 is a wire
// Ports: clock_i clock, d_i data in, q_o data delayed by DEPTH cycles.
module pe_au_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clock_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_regs
            logic [DEPTH-1:0][WIDTH-1:0] stage_q;

            always_ff @(posedge clock_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pe_au_param.sv
// rtl/pe_au_param.sv - pipelined WIDTHxWIDTH multiply-accumulate unit for FIOS PEs
// Ports: clock_i, reset_i (sync, active-high), au (slave side of pe_au_param_if).
// Result P (2*WIDTH+2 bits) = op(M, C, P >> WIDTH), valid L = 1+ABREG+MREG cycles after issue.
module pe_au_param
    import pe_au_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    parameter int CREG  = 1
) (
    input  logic         clock_i,
    input  logic         reset_i,
    pe_au_param_if.slave au
);

    localparam int L     = pe_au_latency(ABREG, MREG);
    localparam int VD    = L - 1;
    localparam int ACC_W = 2 * WIDTH + 2;

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("pe_au_param: WIDTH must be 2..32");
        end
        if (ABREG < 0 || ABREG > 2 || MREG < 0 || MREG > 1 || CREG < 0 || CREG > 1) begin : g_bad_regs
            $error("pe_au_param: ABREG 0..2, MREG 0..1, CREG 0..1");
        end
        // With no pipeline stage there is no cycle in which to load C ahead of use.
        if (CREG == 1 && ABREG + MREG < 1) begin : g_bad_creg
            $error("pe_au_param: CREG=1 needs ABREG+MREG>=1");
        end
    endgenerate

    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_d;
    logic [2*WIDTH-1:0] prod_w;
    logic [2*WIDTH-1:0] prod_d;
    logic [OP_W-1:0]    op_d;
    op_t                op_fin;
    logic               v_fin;
    logic [2*WIDTH-1:0] c_use;

    pe_au_delay_line #(.WIDTH(WIDTH), .DEPTH(ABREG)) u_dl_a (
        .clock_i (clock_i), .d_i (au.A_i), .q_o (a_d)
    );
    pe_au_delay_line #(.WIDTH(WIDTH), .DEPTH(ABREG)) u_dl_b (
        .clock_i (clock_i), .d_i (au.B_i), .q_o (b_d)
    );
    pe_au_delay_line #(.WIDTH(OP_W), .DEPTH(ABREG + MREG)) u_dl_op (
        .clock_i (clock_i), .d_i (au.op_i), .q_o (op_d)
    );

    assign prod_w = {{WIDTH{1'b0}}, a_d} * {{WIDTH{1'b0}}, b_d};

    pe_au_delay_line #(.WIDTH(2 * WIDTH), .DEPTH(MREG)) u_dl_m (
        .clock_i (clock_i), .d_i (prod_w), .q_o (prod_d)
    );

    assign op_fin = op_t'(op_d);

    // Valid tracking needs reset so a reset discards in-flight issues.
    generate
        if (VD == 0) begin : g_v_wire
            assign v_fin = au.valid_i;
        end else begin : g_v_regs
            logic [VD-1:0] v_q;

            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= au.valid_i;
                    for (int i = 1; i < VD; i++) begin
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            assign v_fin = v_q[VD-1];
        end
    endgenerate

    // C register loads independently of valid_i so C can be staged ahead of its issue.
    generate
        if (CREG == 0) begin : g_c_wire
            assign c_use = au.C_i;
        end else begin : g_c_reg
            logic [2*WIDTH-1:0] c_q;

            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    c_q <= '0;
                end else if (au.CREG_en_i) begin
                    c_q <= au.C_i;
                end
            end

            assign c_use = c_q;
        end
    endgenerate

    logic [ACC_W-1:0] p_q;
    logic [ACC_W-1:0] p_d;
    logic             valid_q;
    logic [ACC_W-1:0] m_ext;
    logic [ACC_W-1:0] c_ext;
    logic [ACC_W-1:0] s_ext;

    // S is taken from the live P register, so dependent issues may run back to back.
    always_comb begin
        m_ext = {2'b00, prod_d};
        c_ext = {2'b00, c_use};
        s_ext = {{WIDTH{1'b0}}, p_q[ACC_W-1:WIDTH]};
        p_d   = p_q;
        if (v_fin) begin
            case (op_fin)
                OP_MUL:         p_d = m_ext;
                OP_MAC_C:       p_d = m_ext + c_ext;
                OP_MAC_SHIFT:   p_d = m_ext + s_ext;
                OP_MAC_C_SHIFT: p_d = m_ext + c_ext + s_ext;
                OP_ADD_C:       p_d = c_ext + s_ext;
                OP_CLR:         p_d = '0;
                default:        p_d = p_q;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            valid_q <= v_fin;
        end
    end

    assign au.P_o     = p_q;
    assign au.valid_o = valid_q;

endmodule

// File: tb/tb_pe_au_param.sv
// tb/tb_pe_au_param.sv - self-checking bench for pe_au_param (WIDTH=17, L=3)
module tb_pe_au_param;
    import pe_au_pkg::*;

    localparam int W     = 17;
    localparam int ACC_W = 2 * W + 2;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_au_param_if #(.WIDTH(W)) bus ();

    pe_au_param #(.WIDTH(W), .ABREG(1), .MREG(1), .CREG(1)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .au      (bus)
    );

    typedef struct {
        logic [ACC_W-1:0] p;
        int               cyc;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    bit               mon_en = 1'b0;
    logic [ACC_W-1:0] model_p;
    logic [2*W-1:0]   model_c;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every valid_o must match the oldest expected result and its cycle.
    always @(negedge clk) begin
        if (mon_en && bus.valid_o !== 1'b0) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: valid_o=%b P_o=0x%0h at cycle %0d, required no result", bus.valid_o, bus.P_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.P_o !== e.p || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result: P_o=0x%0h at cycle %0d, required 0x%0h at cycle %0d", bus.P_o, cyc, e.p, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [ACC_W-1:0] model_next(input logic [2:0] op, input logic [W-1:0] a,
                                                    input logic [W-1:0] b, input logic [2*W-1:0] c,
                                                    input logic [ACC_W-1:0] p);
        logic [ACC_W-1:0] m, cc, s;
        m  = ACC_W'(a) * ACC_W'(b);
        cc = ACC_W'(c);
        s  = p >> W;
        case (op)
            3'd0:    return m;
            3'd1:    return m + cc;
            3'd2:    return m + s;
            3'd3:    return m + cc + s;
            3'd4:    return cc + s;
            3'd6:    return '0;
            default: return p;
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.valid_i = v;
        bus.op_i    = op_t'(op);
        bus.A_i     = a;
        bus.B_i     = b;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int t_issue);
        exp_t e;
        model_p = model_next(op, a, b, model_c, model_p);
        e.p     = model_p;
        e.cyc   = t_issue + LAT;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        int t0;
        mon_en = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 17'($urandom), 17'($urandom));
            bus.C_i       = {2'($urandom), 32'($urandom)};
            bus.CREG_en_i = 1'b1;
            step();
        end
        // Issues and a C load presented during reset must be dropped.
        rst = 1'b1;
        drive(1'b1, 3'd0, 17'h1FFFF, 17'h1FFFF);
        for (int i = 0; i < 2; i++) begin
            step();
            checks += 2;
            if (bus.P_o !== '0) begin
                errors++;
                $display("FAIL reset_p: P_o=0x%0h, required 0x0", bus.P_o);
            end
            if (bus.valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid: valid_o=%b, required 0", bus.valid_o);
            end
        end
        rst = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
        bus.CREG_en_i = 1'b0;
        exp_q.delete();
        model_p = '0;
        model_c = '0;
        mon_en  = 1'b1;
        t0 = cyc;
        drive(1'b1, 3'd4, '0, '0);
        bus.C_i = 34'h2AAAA5555;
        push_exp(3'd4, '0, '0, t0);
        step();
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.P_o !== '0) begin
            errors++;
            $display("FAIL reset_creg_cleared: P_o=0x%0h, required 0x0", bus.P_o);
        end
    endtask

    task automatic test_mul;
        int t0;
        t0 = cyc;
        drive(1'b1, 3'd0, 17'h1FFFF, 17'h1FFFF);
        push_exp(3'd0, 17'h1FFFF, 17'h1FFFF, t0);
        step();
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mul_drain: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.P_o !== 36'h3FFFC0001) begin
            errors++;
            $display("FAIL mul_max: P_o=0x%0h, required 0x3FFFC0001", bus.P_o);
        end
    endtask

    task automatic test_mac_c;
        int t0;
        t0 = cyc;
        drive(1'b1, 3'd1, 17'h1FFFF, 17'h1FFFF);
        step();
        drive(1'b0, 3'd0, '0, '0);
        bus.C_i       = 34'h3FFFFFFFF;
        bus.CREG_en_i = 1'b1;
        model_c       = 34'h3FFFFFFFF;
        push_exp(3'd1, 17'h1FFFF, 17'h1FFFF, t0);
        step();
        bus.CREG_en_i = 1'b0;
        bus.C_i       = 34'h1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (bus.P_o !== 36'h7FFFC0000) begin
            errors++;
            $display("FAIL mac_c_fresh: P_o=0x%0h, required 0x7FFFC0000", bus.P_o);
        end
        // C register holds while CREG_en_i is low.
        t0 = cyc;
        drive(1'b1, 3'd1, 17'h1FFFF, 17'h1FFFF);
        bus.C_i = 34'h123;
        step();
        drive(1'b0, 3'd0, '0, '0);
        bus.C_i = 34'h555;
        push_exp(3'd1, 17'h1FFFF, 17'h1FFFF, t0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mac_c_drain: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.P_o !== 36'h7FFFC0000) begin
            errors++;
            $display("FAIL mac_c_reused: P_o=0x%0h, required 0x7FFFC0000", bus.P_o);
        end
    endtask

    task automatic test_chain;
        int t0;
        t0 = cyc;
        drive(1'b1, 3'd0, 17'h1FFFF, 17'h2);
        push_exp(3'd0, 17'h1FFFF, 17'h2, t0);
        step();
        drive(1'b1, 3'd2, 17'h1, 17'h1);
        push_exp(3'd2, 17'h1, 17'h1, t0 + 1);
        step();
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL chain_drain: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.P_o !== 36'h2) begin
            errors++;
            $display("FAIL chain_shift: P_o=0x%0h, required 0x2", bus.P_o);
        end
    endtask

    task automatic test_bubble_hold_clr;
        int t0;
        t0 = cyc;
        drive(1'b1, 3'd0, 17'h1234, 17'h1);
        push_exp(3'd0, 17'h1234, 17'h1, t0);
        step();
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 2;
            if (bus.P_o !== 36'h1234) begin
                errors++;
                $display("FAIL bubble_hold: P_o=0x%0h, required 0x1234", bus.P_o);
            end
            if (bus.valid_o !== 1'b0) begin
                errors++;
                $display("FAIL bubble_valid: valid_o=%b, required 0", bus.valid_o);
            end
        end
        t0 = cyc;
        drive(1'b1, 3'd5, 17'h1FFFF, 17'h1FFFF);
        push_exp(3'd5, 17'h1FFFF, 17'h1FFFF, t0);
        step();
        drive(1'b1, 3'd7, 17'h1FFFF, 17'h3);
        push_exp(3'd7, 17'h1FFFF, 17'h3, t0 + 1);
        step();
        drive(1'b1, 3'd6, 17'h5, 17'h5);
        push_exp(3'd6, 17'h5, 17'h5, t0 + 2);
        step();
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_clr_drain: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.P_o !== '0) begin
            errors++;
            $display("FAIL clr: P_o=0x%0h, required 0x0", bus.P_o);
        end
    endtask

    task automatic test_back_to_back;
        logic           pv, v;
        logic [2:0]     pop, op;
        logic [W-1:0]   pa, pb, a, b;
        logic           en;
        logic [2*W-1:0] c;
        int             pt;
        pv = 1'b0; pop = '0; pa = '0; pb = '0; pt = 0;
        for (int i = 0; i <= 40; i++) begin
            v  = (i < 40) ? 1'($urandom_range(0, 4) != 0) : 1'b0;
            op = 3'($urandom_range(0, 7));
            a  = 17'($urandom);
            b  = 17'($urandom);
            en = 1'($urandom_range(0, 1));
            c  = {2'($urandom), 32'($urandom)};
            drive(v, op, a, b);
            bus.C_i       = c;
            bus.CREG_en_i = en;
            // The previous issue consumes C as loaded by the end of this cycle.
            if (en) model_c = c;
            if (pv) push_exp(pop, pa, pb, pt);
            pv = v; pop = op; pa = a; pb = b; pt = cyc;
            step();
        end
        drive(1'b0, 3'd0, '0, '0);
        bus.CREG_en_i = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.P_o !== model_p) begin
            errors++;
            $display("FAIL b2b_final: P_o=0x%0h, required 0x%0h", bus.P_o, model_p);
        end
    endtask

    task automatic test_reset_midflight;
        int t0;
        t0 = cyc;
        drive(1'b1, 3'd0, 17'h5, 17'h7);
        step();
        rst = 1'b1;
        drive(1'b0, 3'd0, '0, '0);
        step();
        rst = 1'b0;
        model_p = '0;
        model_c = '0;
        checks += 2;
        if (bus.P_o !== '0) begin
            errors++;
            $display("FAIL midflight_p: P_o=0x%0h, required 0x0", bus.P_o);
        end
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midflight_valid: valid_o=%b, required 0", bus.valid_o);
        end
        drive(1'b1, 3'd0, 17'h5, 17'h7);
        push_exp(3'd0, 17'h5, 17'h7, t0 + 2);
        step();
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midflight_drain: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.P_o !== 36'h23) begin
            errors++;
            $display("FAIL midflight_post: P_o=0x%0h, required 0x23", bus.P_o);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.valid_i   = 1'b0;
        bus.op_i      = OP_MUL;
        bus.A_i       = '0;
        bus.B_i       = '0;
        bus.C_i       = '0;
        bus.CREG_en_i = 1'b0;
        model_p       = '0;
        model_c       = '0;
        repeat (3) step();
        test_reset();
        test_mul();
        test_mac_c();
        test_chain();
        test_bubble_hold_clr();
        test_back_to_back();
        test_reset_midflight();
        repeat (5) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d results outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_au_param.md
Name: pe_au_param

Overview:
- Parametrised, behavioural (primitive-free) successor of the PE arithmetic unit used in FIOS Montgomery processing elements.
- Computes WIDTH x WIDTH unsigned products and accumulates them with a C operand and/or the WIDTH-bit right-shifted previous result, per operation.
- Pipeline depth is configurable to match the DSP register options.
- Adds valid tracking, a per-issue opcode (hold/clear/shift modes), synchronous reset and an overflow-free widened result.

Parameters:
- WIDTH, 17, operand width in bits; legal range 2..32.
- ABREG, 1, A/B input register stages; legal range 0..2.
- MREG, 1, multiplier output register stages; legal range 0..1.
- CREG, 1, C input register stages; legal range 0..1. CREG=1 requires ABREG+MREG>=1 (elaboration error otherwise).
- Derived: L = 1+ABREG+MREG, the issue-to-result latency. ACC_W = 2*WIDTH+2, the result width.

Ports:
- clock_i  in  1  clock; all state changes on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  issue strobe; op_i/A_i/B_i are sampled when high.
- op_i  in  3  operation code (pe_au_pkg::op_t).
- A_i  in  WIDTH  multiplicand.
- B_i  in  WIDTH  multiplier.
- C_i  in  2*WIDTH  addend.
- CREG_en_i  in  1  load enable of the C register; ignored when CREG=0.
- P_o  out  ACC_W  registered result (P register).
- valid_o  out  1  high for one cycle per completed valid issue, aligned with P_o.

Behaviour:
Interface (already decided):
- One clock (clock_i); reset_i is synchronous and active-high.
Reset:
- P, C register, every pipeline valid bit and valid_o go to 0.
- A/B/op pipeline data are don't-care.
- Reset mid-operation discards all in-flight issues; no valid_o follows.
- Issues with valid_i=1 in the reset cycle are dropped.
Pipeline:
- Issue sampled at the edge ending cycle t0.
- P register updates at the edge ending cycle t0+L-1.
- P_o and valid_o are seen during cycle t0+L.
- Full throughput: one issue per cycle, no backpressure.
- op travels with A/B through an identical delay line.
- The multiply happens after the ABREG stages, then passes MREG stages.
C timing:
- C is consumed in the cycle the P register updates.
- CREG=0: uses C_i of cycle t0+L-1.
- CREG=1: uses C register content; the register loads C_i when CREG_en_i=1 and holds otherwise. For fresh C, present C_i with CREG_en_i=1 in cycle t0+L-2.
- The C register loads regardless of valid_i.
Final-stage ops (M = delayed product, S = P >> WIDTH of the current P register, zero-extended):
- OP_MUL=0: P=M.
- OP_MAC_C=1: P=M+C.
- OP_MAC_SHIFT=2: P=M+S.
- OP_MAC_C_SHIFT=3: P=M+C+S.
- OP_ADD_C=4: P=C+S.
- OP_HOLD=5: P unchanged.
- OP_CLR=6: P=0.
- 7 (reserved): behaves as OP_HOLD.
Feedback:
- S is taken from the P register itself, so back-to-back dependent issues are legal every cycle for any L.
Bubbles:
- When the final-stage valid is 0, P holds and valid_o=0.
- valid_o=1 for HOLD/CLR/reserved issues too.
Width:
- All sums are computed in ACC_W bits. The maximum is (2^W-1)^2 + 2^(2W)-1 + 2^(W+2)-1 < 2^ACC_W, so no wrap-around is possible.
- Inputs are unsigned.
Depth 0:
- ABREG=MREG=0 (L=1) makes the delay lines pure wires; P remains the only register.

Decomposition:
- pe_au_pkg holds: typedef enum logic[2:0] op_t with the codes above; function pe_au_latency(ABREG,MREG); localparam OP_W=3.
- Sub-module pe_au_delay_line #(WIDTH,DEPTH): a reset-free data shift register with DEPTH=0 as pass-through.
- It is instantiated for A, B, op and product.
- The valid delay line uses its own resettable flops inside pe_au_param.

Test Plan (WIDTH=17, ABREG=1, MREG=1, CREG=1, L=3):
- Reset: reset_i=1 for 2 cycles after random activity -> P_o=0, valid_o=0 next cycle; C register cleared (OP_ADD_C with CREG_en_i=0 yields 0).
- OP_MUL A=B=0x1FFFF issued at t0 -> valid_o=1 only in cycle t0+3, P_o=0x3FFFC0001.
- OP_MAC_C A=B=0x1FFFF, C_i=0x3FFFFFFFF with CREG_en_i=1 in cycle t0+1 -> P_o=0x7FFFC0000. Repeat with CREG_en_i=0 and a different C_i -> same C reused.
- Chain: OP_MUL A=0x1FFFF,B=2 at t0, then OP_MAC_SHIFT A=1,B=1 at t0+1 -> P_o=0x3FFFE at t0+3, then P_o=0x2 at t0+4, valid_o high both cycles.
- Bubble/hold/clear: P_o=0x1234; valid_i=0 for 3 cycles -> P_o holds, valid_o=0. OP_HOLD -> P_o=0x1234, valid_o=1. Op 7 -> same. OP_CLR -> P_o=0.
- Reset mid-flight: issue OP_MUL 5x7 at t0, reset_i=1 in t0+1 -> valid_o stays 0, P_o=0. Issue at t0+2 (post-reset) -> P_o=0x23 at t0+5.
